// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: wait for BAT and ID, exchange commands with ACK/retry, then gate the packet decoder.
// Build option: define SAMPLE_RATE_CFG_EN to send 0xF3 <SAMPLE_RATE> ahead of 0xF4.
module ps2_mouse_init_ctrl #(
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned ACK_TIMEOUT = 33,
   parameter logic [7:0]  SAMPLE_RATE = 8'd100
) (
   input  logic       ps2_clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] tx_byte,
   output logic       tx_req,
   input  logic       tx_done,
   output logic       stream_en,
   output logic       init_done,
   output logic       init_fail,
   output logic [1:0] retry_cnt,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] S_WAIT_BAT = 4'd0;
   localparam logic [3:0] S_WAIT_ID  = 4'd1;
   localparam logic [3:0] S_SEND     = 4'd2;
   localparam logic [3:0] S_WAIT_ACK = 4'd3;
   localparam logic [3:0] S_STREAM   = 4'd4;
   localparam logic [3:0] S_FAIL     = 4'd5;

   localparam logic [7:0] RX_BAT_OK  = 8'hAA;
   localparam logic [7:0] RX_ID      = 8'h00;
   localparam logic [7:0] RX_ACK     = 8'hFA;
   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;

   localparam int unsigned      TO_W        = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LIMIT    = ACK_TIMEOUT[TO_W-1:0];
   localparam logic [1:0]       RETRY_LIMIT = MAX_RETRY[1:0];

`ifdef SAMPLE_RATE_CFG_EN
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [1:0] LAST_IDX     = 2'd2;

   function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_SET_RATE;
         2'd1:    return SAMPLE_RATE;
         default: return CMD_ENABLE;
      endcase
   endfunction
`else
   localparam logic [1:0] LAST_IDX = 2'd0;

   function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
      return {8{idx == LAST_IDX}} & CMD_ENABLE;
   endfunction

   // The rate byte has no role when only 0xF4 is sent.
   logic unused_sample_rate;
   assign unused_sample_rate = ^SAMPLE_RATE;
`endif

   logic [3:0]      state_q,     state_d;
   logic [7:0]      tx_byte_q,   tx_byte_d;
   logic            tx_req_q,    tx_req_d;
   logic            stream_en_q, stream_en_d;
   logic            init_done_q, init_done_d;
   logic            init_fail_q, init_fail_d;
   logic [1:0]      retry_cnt_q, retry_cnt_d;
   logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
   logic [1:0]      cmd_idx_q,   cmd_idx_d;
   logic            reset_cmd_q, reset_cmd_d;

   logic ack_rx;
   logic bad_rx;
   logic timed_out;

   assign ack_rx    = rx_valid && (rx_byte == RX_ACK);
   assign bad_rx    = (rx_valid && !ack_rx) || rx_err;
   assign timed_out = (to_cnt_q == TO_LIMIT);

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      tx_byte_d   = tx_byte_q;
      tx_req_d    = tx_req_q;
      stream_en_d = stream_en_q;
      init_done_d = init_done_q;
      init_fail_d = init_fail_q;
      retry_cnt_d = retry_cnt_q;
      to_cnt_d    = to_cnt_q;
      cmd_idx_d   = cmd_idx_q;
      reset_cmd_d = reset_cmd_q;

      case (state_q)
         S_WAIT_BAT: begin
            if (rx_valid && (rx_byte == RX_BAT_OK)) begin
               state_d = S_WAIT_ID;
            end else if (rx_valid || rx_err) begin
               tx_byte_d   = CMD_RESET;
               tx_req_d    = 1'b1;
               reset_cmd_d = 1'b1;
               retry_cnt_d = 2'd0;
               state_d     = S_SEND;
            end
         end

         S_WAIT_ID: begin
            if (rx_valid && (rx_byte == RX_ID)) begin
               cmd_idx_d   = 2'd0;
               tx_byte_d   = cmd_byte(2'd0);
               tx_req_d    = 1'b1;
               reset_cmd_d = 1'b0;
               retry_cnt_d = 2'd0;
               state_d     = S_SEND;
            end else if (rx_valid || rx_err) begin
               // A wrong ID is handled like a failed self-test.
               tx_byte_d   = CMD_RESET;
               tx_req_d    = 1'b1;
               reset_cmd_d = 1'b1;
               retry_cnt_d = 2'd0;
               state_d     = S_SEND;
            end
         end

         S_SEND: begin
            if (tx_done) begin
               tx_req_d = 1'b0;
               to_cnt_d = '0;
               state_d  = S_WAIT_ACK;
            end
         end

         S_WAIT_ACK: begin
            if (!timed_out) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if (ack_rx) begin
               retry_cnt_d = 2'd0;
               if (reset_cmd_q) begin
                  reset_cmd_d = 1'b0;
                  state_d     = S_WAIT_BAT;
               end else if (cmd_idx_q == LAST_IDX) begin
                  stream_en_d = 1'b1;
                  init_done_d = 1'b1;
                  state_d     = S_STREAM;
               end else begin
                  cmd_idx_d = cmd_idx_q + 2'd1;
                  tx_byte_d = cmd_byte(cmd_idx_q + 2'd1);
                  tx_req_d  = 1'b1;
                  state_d   = S_SEND;
               end
            end else if (bad_rx || timed_out) begin
               // A retry resends only the byte still held in tx_byte.
               if (retry_cnt_q < RETRY_LIMIT) begin
                  retry_cnt_d = retry_cnt_q + 2'd1;
                  tx_req_d    = 1'b1;
                  state_d     = S_SEND;
               end else begin
                  init_fail_d = 1'b1;
                  stream_en_d = 1'b0;
                  tx_req_d    = 1'b0;
                  state_d     = S_FAIL;
               end
            end
         end

         S_STREAM: begin
            tx_req_d = 1'b0;
         end

         S_FAIL: begin
            tx_req_d    = 1'b0;
            stream_en_d = 1'b0;
         end

         default: begin
            tx_req_d = 1'b0;
            state_d  = S_WAIT_BAT;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all of them sample pre-edge values.
   always_ff @(negedge ps2_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_WAIT_BAT;
         tx_byte_q   <= 8'h00;
         tx_req_q    <= 1'b0;
         stream_en_q <= 1'b0;
         init_done_q <= 1'b0;
         init_fail_q <= 1'b0;
         retry_cnt_q <= 2'd0;
         to_cnt_q    <= '0;
         cmd_idx_q   <= 2'd0;
         reset_cmd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_byte_q   <= tx_byte_d;
         tx_req_q    <= tx_req_d;
         stream_en_q <= stream_en_d;
         init_done_q <= init_done_d;
         init_fail_q <= init_fail_d;
         retry_cnt_q <= retry_cnt_d;
         to_cnt_q    <= to_cnt_d;
         cmd_idx_q   <= cmd_idx_d;
         reset_cmd_q <= reset_cmd_d;
      end
   end

   assign tx_byte   = tx_byte_q;
   assign tx_req    = tx_req_q;
   assign stream_en = stream_en_q;
   assign init_done = init_done_q;
   assign init_fail = init_fail_q;
   assign retry_cnt = retry_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Self-checking bench for ps2_mouse_init_ctrl: vector table plus scoreboarded command exchanges.
// Honours SAMPLE_RATE_CFG_EN the same way as the design.
module tb_ps2_mouse_init_ctrl;

   localparam logic [3:0] ST_WAIT_BAT = 4'd0;
   localparam logic [3:0] ST_WAIT_ID  = 4'd1;
   localparam logic [3:0] ST_SEND     = 4'd2;
   localparam logic [3:0] ST_WAIT_ACK = 4'd3;
   localparam logic [3:0] ST_STREAM   = 4'd4;
   localparam logic [3:0] ST_FAIL     = 4'd5;

   logic       ps2_clk;
   logic       reset;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic [7:0] tx_byte;
   logic       tx_req;
   logic       tx_done;
   logic       stream_en;
   logic       init_done;
   logic       init_fail;
   logic [1:0] retry_cnt;
   logic [3:0] state_dbg;

   ps2_mouse_init_ctrl #(
      .MAX_RETRY  (3),
      .ACK_TIMEOUT(33),
      .SAMPLE_RATE(8'd100)
   ) dut (
      .ps2_clk  (ps2_clk),
      .reset    (reset),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .tx_byte  (tx_byte),
      .tx_req   (tx_req),
      .tx_done  (tx_done),
      .stream_en(stream_en),
      .init_done(init_done),
      .init_fail(init_fail),
      .retry_cnt(retry_cnt),
      .state_dbg(state_dbg)
   );

   initial ps2_clk = 1'b1;
   always #5 ps2_clk = ~ps2_clk;

   typedef struct {
      logic       rv;
      logic       re;
      logic [7:0] rb;
      logic       td;
      logic [3:0] st;
      logic       req;
      logic [7:0] tb;
      logic       sen;
      logic       done;
      logic       fail;
      logic [1:0] rc;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] cmds[$];
   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         tx_count = 0;

   function automatic vec_t mk(input logic rv, input logic re, input logic [7:0] rb, input logic td,
                               input logic [3:0] st, input logic req, input logic [7:0] tb,
                               input logic sen, input logic done, input logic fail, input logic [1:0] rc);
      vec_t v;
      v.rv = rv; v.re = re; v.rb = rb; v.td = td;
      v.st = st; v.req = req; v.tb = tb; v.sen = sen; v.done = done; v.fail = fail; v.rc = rc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge ps2_clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_err();
      rx_err = 1'b1;
      tick();
      rx_err = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rx_valid = 1'b0; rx_err = 1'b0; tx_done = 1'b0; rx_byte = 8'h00;
      reset = 1'b1;
      tick();
      check("reset state", state_dbg, ST_WAIT_BAT);
      check("reset tx_req", tx_req, 0);
      check("reset tx_byte", tx_byte, 8'h00);
      check("reset flags", {stream_en, init_done, init_fail}, 3'b000);
      check("reset retry_cnt", retry_cnt, 0);
      reset = 1'b0;
   endtask

   // Waits for the DUT to request a transmit, compares against the scoreboard, then completes it.
   task automatic serve_tx(input string name);
      int         waited;
      logic [7:0] exp_b;
      waited = 0;
      while (tx_req !== 1'b1 && waited < 80) begin
         tick();
         waited++;
      end
      check({name, " tx_req"}, tx_req, 1);
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s scoreboard: transmit of 0x%0h with nothing expected", name, tx_byte);
         return;
      end
      exp_b = exp_q.pop_front();
      check({name, " tx_byte"}, tx_byte, exp_b);
      if (tx_req !== 1'b1) return;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tx_count++;
      check({name, " tx_req drop"}, tx_req, 0);
      check({name, " in WAIT_ACK"}, state_dbg, ST_WAIT_ACK);
   endtask

   task automatic ack_rest(input int start);
      for (int i = start; i < cmds.size(); i++) begin
         exp_q.push_back(cmds[i]);
         serve_tx($sformatf("cmd%0d", i));
         send_rx(8'hFA);
      end
   endtask

   task automatic check_stream(input string name);
      check({name, " state STREAM"}, state_dbg, ST_STREAM);
      check({name, " stream_en/init_done"}, {stream_en, init_done, init_fail}, 3'b110);
      check({name, " retry_cnt"}, retry_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t0;
      logic [3:0] st_after_ack;

`ifdef SAMPLE_RATE_CFG_EN
      cmds.push_back(8'hF3);
      cmds.push_back(8'h64);
      cmds.push_back(8'hF4);
`else
      cmds.push_back(8'hF4);
`endif

      // rv re rb td | st req tb sen done fail rc
      tbl.push_back(mk(0, 0, 8'h00, 0, ST_WAIT_BAT, 0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8'hAA, 0, ST_WAIT_ID,  0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, ST_WAIT_ID,  0, 8'h00, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8'h00, 0, ST_SEND,     1, cmds[0], 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 0, ST_SEND,     1, cmds[0], 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8'hFA, 0, ST_SEND,     1, cmds[0], 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, ST_WAIT_ACK, 0, cmds[0], 0, 0, 0, 0));
`ifdef SAMPLE_RATE_CFG_EN
      tbl.push_back(mk(1, 0, 8'hFA, 0, ST_SEND,     1, 8'h64, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, ST_WAIT_ACK, 0, 8'h64, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 8'hFA, 0, ST_SEND,     1, 8'hF4, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 8'h00, 1, ST_WAIT_ACK, 0, 8'hF4, 0, 0, 0, 0));
`endif
      tbl.push_back(mk(1, 0, 8'hFA, 0, ST_STREAM,   0, 8'hF4, 1, 1, 0, 0));
      tbl.push_back(mk(0, 1, 8'h00, 0, ST_STREAM,   0, 8'hF4, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 8'hAA, 1, ST_STREAM,   0, 8'hF4, 1, 1, 0, 0));

      // Nominal bring-up, one table row per falling edge.
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         rx_valid = tbl[i].rv;
         rx_err   = tbl[i].re;
         rx_byte  = tbl[i].rb;
         tx_done  = tbl[i].td;
         tick();
         rx_valid = 1'b0; rx_err = 1'b0; tx_done = 1'b0;
         check($sformatf("vec%0d state", i), state_dbg, tbl[i].st);
         check($sformatf("vec%0d tx_req", i), tx_req, tbl[i].req);
         check($sformatf("vec%0d tx_byte", i), tx_byte, tbl[i].tb);
         check($sformatf("vec%0d flags", i), {stream_en, init_done, init_fail}, {tbl[i].sen, tbl[i].done, tbl[i].fail});
         check($sformatf("vec%0d retry_cnt", i), retry_cnt, tbl[i].rc);
      end

      // Two Resends on the first command, then ACK.
      do_reset();
      send_rx(8'hAA);
      send_rx(8'h00);
      t0 = tx_count;
      repeat (3) exp_q.push_back(cmds[0]);
      serve_tx("resend#1");
      send_rx(8'hFE);
      check("resend retry_cnt 1", retry_cnt, 1);
      serve_tx("resend#2");
      send_rx(8'hFE);
      check("resend retry_cnt 2", retry_cnt, 2);
      serve_tx("resend#3");
      send_rx(8'hFA);
      check("resend retry_cnt cleared", retry_cnt, 0);
      check("resend transmit count", tx_count - t0, 3);
      ack_rest(1);
      check_stream("resend");

      // Every transmit answered with Resend: fail after the fourth response.
      do_reset();
      send_rx(8'hAA);
      send_rx(8'h00);
      repeat (4) exp_q.push_back(cmds[0]);
      for (int i = 0; i < 4; i++) begin
         serve_tx($sformatf("exhaust#%0d", i));
         send_rx(8'hFE);
      end
      check("exhaust state FAIL", state_dbg, ST_FAIL);
      check("exhaust flags", {stream_en, init_done, init_fail}, 3'b001);
      check("exhaust tx_req", tx_req, 0);
      check("exhaust retry_cnt saturated", retry_cnt, 3);
      send_rx(8'hAA);
      idle(3);
      check("fail is sticky", {state_dbg, init_fail, tx_req}, {ST_FAIL, 1'b1, 1'b0});

      // Bad self-test results and a wrong ID all lead to 0xFF.
      do_reset();
      send_err();
      check("bat rx_err -> reset cmd", {state_dbg, tx_req, tx_byte}, {ST_SEND, 1'b1, 8'hFF});
      exp_q.push_back(8'hFF);
      serve_tx("bat err FF");
      send_rx(8'hFA);
      check("FF acked -> WAIT_BAT", state_dbg, ST_WAIT_BAT);
      send_rx(8'hAA);
      send_rx(8'h03);
      check("bad id -> reset cmd", {state_dbg, tx_req, tx_byte}, {ST_SEND, 1'b1, 8'hFF});
      exp_q.push_back(8'hFF);
      serve_tx("bad id FF");
      send_rx(8'hFA);
      send_rx(8'hFC);
      check("bat FC -> reset cmd", tx_byte, 8'hFF);
      exp_q.push_back(8'hFF);
      serve_tx("bat FC FF");
      send_rx(8'hFA);
      check("FC path back to WAIT_BAT", state_dbg, ST_WAIT_BAT);
      send_rx(8'hAA);
      send_rx(8'h00);
      ack_rest(0);
      check_stream("bat recovery");

      // Silence after tx_done: 33 quiet edges are tolerated, the next one retries.
      do_reset();
      send_rx(8'hAA);
      send_rx(8'h00);
      exp_q.push_back(cmds[0]);
      serve_tx("timeout first");
      idle(33);
      check("timeout still waiting", {state_dbg, tx_req}, {ST_WAIT_ACK, 1'b0});
      tick();
      check("timeout retransmit", {state_dbg, tx_req, tx_byte}, {ST_SEND, 1'b1, cmds[0]});
      check("timeout retry_cnt", retry_cnt, 1);
      exp_q.push_back(cmds[0]);
      serve_tx("timeout second");
      idle(33);
      send_rx(8'hFA);
      st_after_ack = (cmds.size() == 1) ? ST_STREAM : ST_SEND;
      check("ack beats timeout state", state_dbg, st_after_ack);
      check("ack beats timeout retry_cnt", retry_cnt, 0);

      // Reset asserted between edges while a command is pending.
      do_reset();
      send_rx(8'hAA);
      send_rx(8'h00);
      check("pre-reset in SEND", {state_dbg, tx_req}, {ST_SEND, 1'b1});
      #2;
      reset = 1'b1;
      #1;
      check("async reset tx_req", tx_req, 0);
      check("async reset state", state_dbg, ST_WAIT_BAT);
      #3;
      reset = 1'b0;
      tick();
      check("after reset idle", {state_dbg, tx_req}, {ST_WAIT_BAT, 1'b0});

`ifdef SAMPLE_RATE_CFG_EN
      // Resend on the rate byte repeats only the rate byte.
      do_reset();
      send_rx(8'hAA);
      send_rx(8'h00);
      exp_q.push_back(8'hF3);
      serve_tx("rate F3");
      send_rx(8'hFA);
      exp_q.push_back(8'h64);
      serve_tx("rate 64");
      send_rx(8'hFE);
      check("rate resend retry_cnt", retry_cnt, 1);
      exp_q.push_back(8'h64);
      serve_tx("rate 64 again");
      send_rx(8'hFA);
      exp_q.push_back(8'hF4);
      serve_tx("rate F4");
      send_rx(8'hFA);
      check_stream("rate cfg");
`endif

      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
